// File: rtl/encoder_sample_avs.sv
//------------------------------------------------------------------------------
// encoder_sample_avs: periodic position/velocity sampler for the quadrature
// counter, exposed through an Avalon-MM slave.          Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module encoder_sample_avs #(
    parameter logic [31:0] PERIOD_DEFAULT = 32'd50000,
    parameter logic [31:0] MIN_PERIOD     = 32'd2
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic [31:0] count,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        sample_irq
);

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_PERIOD = 3'd1;
    localparam logic [2:0] ADDR_POS    = 3'd2;
    localparam logic [2:0] ADDR_DELTA  = 3'd3;
    localparam logic [2:0] ADDR_LIVE   = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    logic        enable_q, irq_en_q;
    logic [31:0] period_q, pos_q, delta_q, prev_q;
    logic [31:0] timer_q, timer_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic [15:0] seq_q;
    logic [31:0] readdata_q, readdata_d;
    logic        irq_q;

    logic        wr_ctrl, wr_period, wr_status;
    logic        clr_valid, clr_overrun;
    logic        tick, enable_rise;
    logic [31:0] eff_period, new_eff_period;

    always_comb begin
        wr_ctrl     = avs_write && (avs_address == ADDR_CTRL);
        wr_period   = avs_write && (avs_address == ADDR_PERIOD);
        wr_status   = avs_write && (avs_address == ADDR_STATUS);
        clr_valid   = wr_status && avs_writedata[0];
        clr_overrun = wr_status && avs_writedata[1];
        enable_rise = wr_ctrl && avs_writedata[0] && !enable_q;

        eff_period     = (period_q < MIN_PERIOD) ? MIN_PERIOD : period_q;
        new_eff_period = (avs_writedata < MIN_PERIOD) ? MIN_PERIOD : avs_writedata;

        // A disabling CTRL write or any PERIOD write cancels a tick due this cycle
        tick = enable_q && (timer_q == 32'd0) && !wr_period
               && !(wr_ctrl && !avs_writedata[0]);

        timer_d = timer_q - 32'd1;
        if (wr_period) begin
            timer_d = new_eff_period - 32'd1;
        end else if (!enable_q || tick) begin
            timer_d = eff_period - 32'd1;
        end

        // Set dominates clear; a same-cycle clear of valid also masks overrun
        valid_d = valid_q;
        if (clr_valid) valid_d = 1'b0;
        if (tick)      valid_d = 1'b1;

        overrun_d = overrun_q;
        if (clr_overrun)                      overrun_d = 1'b0;
        if (tick && valid_q && !clr_valid)    overrun_d = 1'b1;

        readdata_d = readdata_q;
        if (avs_read) begin
            case (avs_address)
                ADDR_CTRL:   readdata_d = {30'd0, irq_en_q, enable_q};
                ADDR_PERIOD: readdata_d = period_q;
                ADDR_POS:    readdata_d = pos_q;
                ADDR_DELTA:  readdata_d = delta_q;
                ADDR_LIVE:   readdata_d = count;
                ADDR_STATUS: readdata_d = {seq_q, 14'd0, overrun_q, valid_q};
                default:     readdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            period_q   <= PERIOD_DEFAULT;
            pos_q      <= 32'd0;
            delta_q    <= 32'd0;
            prev_q     <= 32'd0;
            timer_q    <= 32'd0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            seq_q      <= 16'd0;
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                enable_q <= avs_writedata[0];
                irq_en_q <= avs_writedata[1];
            end
            if (wr_period) begin
                period_q <= avs_writedata;
            end
            if (enable_rise) begin
                prev_q <= count;
            end
            if (tick) begin
                pos_q   <= count;
                delta_q <= count - prev_q;
                prev_q  <= count;
                seq_q   <= seq_q + 16'd1;
            end
            timer_q    <= timer_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_en_q & valid_q;
        end
    end

    assign avs_readdata = readdata_q;
    assign sample_irq   = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_encoder_sample_avs.sv
//------------------------------------------------------------------------------
// tb_encoder_sample_avs: directed, table-driven bench for encoder_sample_avs.
//------------------------------------------------------------------------------
`default_nettype none

module tb_encoder_sample_avs;

    logic        clk50 = 1'b0;
    logic        reset_n;
    logic [31:0] count;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        sample_irq;

    // count = base + step * (cycles since cyc0); cyc is the posedge index
    logic [31:0] cyc  = 32'd0;
    logic [31:0] cyc0 = 32'd0;
    logic [31:0] base = 32'd0;
    logic [31:0] step = 32'd0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] period;
        logic [31:0] base;
        logic [31:0] step;
        logic [31:0] exp_pos;
        logic [31:0] exp_delta;
        int          exp_gap;
    } vec_t;

    vec_t vecs[6];

    encoder_sample_avs dut (
        .clk50         (clk50),
        .reset_n       (reset_n),
        .count         (count),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .sample_irq    (sample_irq)
    );

    always #10 clk50 = ~clk50;
    always @(posedge clk50) cyc <= cyc + 32'd1;
    assign count = base + step * (cyc - cyc0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input int at_edge);
        @(negedge clk50);
        while (at_edge > 0 && int'(cyc) < at_edge - 1) @(negedge clk50);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(posedge clk50);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk50);
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk50);
        #1;
        d        = avs_readdata;
        avs_read = 1'b0;
    endtask

    // Enables with a fresh count ramp so that count equals b on the enabling edge
    task automatic start(input logic [31:0] b, input logic [31:0] s,
                         input logic [31:0] ctrl, output int e);
        @(negedge clk50);
        base          = b;
        step          = s;
        cyc0          = cyc;
        avs_address   = 3'd0;
        avs_writedata = ctrl;
        avs_write     = 1'b1;
        @(posedge clk50);
        #1;
        avs_write = 1'b0;
        e = int'(cyc);
    endtask

    // Polls STATUS every cycle; returns the edge on which seq changed
    task automatic wait_tick(output int tedge, output logic [15:0] sq);
        logic [31:0] d;
        logic [15:0] s0;
        bit          seen;
        seen = 1'b0;
        bus_read(3'd5, d);
        s0    = d[31:16];
        sq    = s0;
        tedge = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            bus_read(3'd5, d);
            if (d[31:16] != s0) begin
                seen  = 1'b1;
                tedge = int'(cyc) - 1;
                sq    = d[31:16];
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL tick_timeout: no sample seen, seq stuck at 0x%04h expected a change", s0);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [15:0] sq, sq2, s_before;
        int e, t, t2, w;

        vecs[0] = '{32'd10, 32'h0000_0000, 32'd3,         32'h0000_001E, 32'h0000_001E, 10};
        vecs[1] = '{32'd10, 32'h0000_0100, 32'hFFFF_FFFD, 32'h0000_00E2, 32'hFFFF_FFE2, 10};
        vecs[2] = '{32'd10, 32'hFFFF_FFF8, 32'd3,         32'h0000_0016, 32'h0000_001E, 10};
        vecs[3] = '{32'd0,  32'h0000_1000, 32'd5,         32'h0000_100A, 32'h0000_000A, 2};
        vecs[4] = '{32'd1,  32'h0000_2000, 32'hFFFF_FFFF, 32'h0000_1FFE, 32'hFFFF_FFFE, 2};
        vecs[5] = '{32'd2,  32'h0000_0000, 32'd7,         32'h0000_000E, 32'h0000_000E, 2};

        reset_n       = 1'b0;
        avs_address   = 3'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        base          = 32'h1234_5678;
        repeat (3) @(posedge clk50);
        #1;
        check("rst_readdata", avs_readdata, 32'd0);
        check("rst_irq", {31'd0, sample_irq}, 32'd0);
        @(negedge clk50);
        reset_n = 1'b1;

        // Reset register values and one-cycle read latency
        bus_read(3'd1, d);
        check("rst_period", d, 32'd50000);
        @(negedge clk50);
        avs_address = 3'd0;
        avs_read    = 1'b1;
        #1;
        check("read_hold_before_edge", avs_readdata, 32'd50000);
        @(posedge clk50);
        #1;
        avs_read = 1'b0;
        check("rst_ctrl", avs_readdata, 32'd0);
        bus_read(3'd2, d); check("rst_pos", d, 32'd0);
        bus_read(3'd3, d); check("rst_delta", d, 32'd0);
        bus_read(3'd5, d); check("rst_status", d, 32'd0);
        bus_read(3'd6, d); check("unmapped_6", d, 32'd0);
        bus_read(3'd4, d); check("live", d, 32'h1234_5678);

        // Static count, PERIOD=10: ticks 10/20/30 cycles after enable
        bus_write(3'd1, 32'd10, 0);
        start(32'h7FFF_FFFF, 32'd0, 32'd1, e);
        wait_tick(t, sq);
        check("static_tick1_gap", t - e, 32'd10);
        check("static_seq1", {16'd0, sq}, 32'd1);
        wait_tick(t, sq);
        check("static_tick2_gap", t - e, 32'd20);
        check("static_seq2", {16'd0, sq}, 32'd2);
        wait_tick(t, sq);
        check("static_tick3_gap", t - e, 32'd30);
        check("static_seq3", {16'd0, sq}, 32'd3);
        bus_read(3'd2, d); check("static_pos", d, 32'h7FFF_FFFF);
        bus_read(3'd3, d); check("static_delta", d, 32'd0);
        bus_read(3'd5, d); check("overrun_status", d, 32'h0003_0003);

        // Interrupt: enable irq, then W1C both status bits
        bus_write(3'd0, 32'd3, 0);
        @(posedge clk50);
        #1;
        check("irq_asserted", {31'd0, sample_irq}, 32'd1);
        bus_write(3'd5, 32'd3, 0);
        check("irq_still_high_on_clear", {31'd0, sample_irq}, 32'd1);
        @(posedge clk50);
        #1;
        check("irq_dropped", {31'd0, sample_irq}, 32'd0);
        bus_read(3'd5, d); check("status_cleared", d, 32'h0003_0000);

        // W1C of valid on the very edge of a tick: valid stays, no overrun
        wait_tick(t, sq);
        bus_write(3'd5, 32'd1, t + 10);
        bus_read(3'd5, d); check("w1c_vs_tick", d, 32'h0005_0001);

        // Disabling write on the due edge suppresses that tick; state retained
        bus_write(3'd0, 32'd0, t + 20);
        repeat (15) @(posedge clk50);
        bus_read(3'd5, d); check("disable_suppress", d, 32'h0005_0001);
        bus_read(3'd2, d); check("disable_pos_kept", d, 32'h7FFF_FFFF);

        // Velocity and period-clamp vectors
        for (int i = 0; i < 6; i++) begin
            bus_write(3'd0, 32'd0, 0);
            bus_write(3'd5, 32'd3, 0);
            bus_write(3'd1, vecs[i].period, 0);
            bus_read(3'd5, d);
            s_before = d[31:16];
            start(vecs[i].base, vecs[i].step, 32'd1, e);
            wait_tick(t, sq);
            check($sformatf("vec%0d_gap", i), t - e, vecs[i].exp_gap);
            check($sformatf("vec%0d_seq_step", i), {16'd0, 16'(sq - s_before)}, 32'd1);
            bus_read(3'd2, d); check($sformatf("vec%0d_pos", i), d, vecs[i].exp_pos);
            bus_read(3'd3, d); check($sformatf("vec%0d_delta", i), d, vecs[i].exp_delta);
        end

        // PERIOD rewrite mid-count restarts the timer from the write
        bus_write(3'd0, 32'd0, 0);
        bus_write(3'd5, 32'd3, 0);
        bus_write(3'd1, 32'd10, 0);
        start(32'd0, 32'd1, 32'd1, e);
        wait_tick(t, sq);
        bus_write(3'd1, 32'd20, t + 4);
        w = int'(cyc);
        wait_tick(t2, sq2);
        check("period_rewrite_gap", t2 - w, 32'd20);
        check("period_rewrite_seq", {16'd0, 16'(sq2 - sq)}, 32'd1);

        // Asynchronous reset mid-operation
        bus_write(3'd0, 32'd3, 0);
        wait_tick(t, sq);
        repeat (2) @(posedge clk50);
        #1;
        check("pre_reset_irq", {31'd0, sample_irq}, 32'd1);
        bus_read(3'd5, d);
        @(posedge clk50);
        #5;
        reset_n = 1'b0;
        #1;
        check("async_rst_readdata", avs_readdata, 32'd0);
        check("async_rst_irq", {31'd0, sample_irq}, 32'd0);
        repeat (2) @(negedge clk50);
        reset_n = 1'b1;
        bus_read(3'd1, d); check("post_rst_period", d, 32'd50000);
        bus_read(3'd0, d); check("post_rst_ctrl", d, 32'd0);
        bus_read(3'd2, d); check("post_rst_pos", d, 32'd0);
        repeat (30) @(posedge clk50);
        bus_read(3'd5, d); check("post_rst_no_ticks", d, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
